// File: rtl/simplez_sequencer.sv
// Simplez sequencer: fetch/decode/execute control for a 512x12 memory whose
// read data is registered on the falling edge (address at a rising edge,
// data valid at the next rising edge). Holds PC, RI and AC.
// Optional build macro SIMPLEZ_SINGLE_STEP_EN adds a `step` input and a
// WAIT_STEP state that gates every instruction fetch.
module simplez_sequencer #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rstn,
`ifdef SIMPLEZ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ac,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  localparam logic [2:0] OP_ST  = 3'o0;
  localparam logic [2:0] OP_LD  = 3'o1;
  localparam logic [2:0] OP_ADD = 3'o2;
  localparam logic [2:0] OP_BR  = 3'o3;
  localparam logic [2:0] OP_BZ  = 3'o4;
  localparam logic [2:0] OP_CLR = 3'o5;
  localparam logic [2:0] OP_DEC = 3'o6;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED,
    S_WAIT_STEP
  } state_t;

  // Where every "go fetch the next instruction" transition lands. With
  // single-step enabled the fetch address is parked and we wait for `step`.
`ifdef SIMPLEZ_SINGLE_STEP_EN
  localparam state_t S_NEXT = S_WAIT_STEP;
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] ri, ri_n;
  logic [DATA_W-1:0] ac_n, wdata_n;
  logic [ADDR_W-1:0] pc_n, addr_n;
  logic              we_n, halted_n;

  logic [2:0]        op;
  logic [ADDR_W-1:0] cd;
  logic [ADDR_W-1:0] pc_inc;

  assign op     = ri[DATA_W-1 -: 3];
  assign cd     = ri[ADDR_W-1:0];
  assign pc_inc = pc + ADDR_W'(1);

  // Next-state and next-register values; everything holds unless a state
  // says otherwise, and the write strobe defaults low so it only lives for
  // the single EXEC cycle of an ST.
  always_comb begin
    state_n  = state;
    ri_n     = ri;
    pc_n     = pc;
    ac_n     = ac;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    we_n     = 1'b0;
    halted_n = halted;
    case (state)
      S_FETCH: begin
        ri_n    = mem_rdata;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        pc_n = pc_inc;
        case (op)
          OP_LD, OP_ADD: begin
            addr_n  = cd;
            state_n = S_EXEC;
          end
          OP_ST: begin
            addr_n  = cd;
            wdata_n = ac;
            we_n    = 1'b1;
            state_n = S_EXEC;
          end
          OP_BR: begin
            pc_n    = cd;
            addr_n  = cd;
            state_n = S_NEXT;
          end
          OP_BZ: begin
            if (ac == '0) begin
              pc_n   = cd;
              addr_n = cd;
            end else begin
              addr_n = pc_inc;
            end
            state_n = S_NEXT;
          end
          OP_CLR: begin
            ac_n    = '0;
            addr_n  = pc_inc;
            state_n = S_NEXT;
          end
          OP_DEC: begin
            ac_n    = ac - DATA_W'(1);
            addr_n  = pc_inc;
            state_n = S_NEXT;
          end
          default: begin
            // HALT: PC stays on the HALT instruction itself.
            pc_n     = pc;
            halted_n = 1'b1;
            state_n  = S_HALTED;
          end
        endcase
      end
      S_EXEC: begin
        case (op)
          OP_LD:   ac_n = mem_rdata;
          OP_ADD:  ac_n = ac + mem_rdata;
          default: ac_n = ac;
        endcase
        addr_n  = pc;
        state_n = S_NEXT;
      end
      S_HALTED: begin
        state_n = S_HALTED;
      end
      S_WAIT_STEP: begin
`ifdef SIMPLEZ_SINGLE_STEP_EN
        if (step) state_n = S_FETCH;
`else
        state_n = S_FETCH;
`endif
      end
      default: state_n = S_NEXT;
    endcase
  end

  // State and datapath registers; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_NEXT;
      ri        <= '0;
      pc        <= PC0;
      ac        <= '0;
      mem_addr  <= PC0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      ri        <= ri_n;
      pc        <= pc_n;
      ac        <= ac_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      halted    <= halted_n;
    end
  end

endmodule

// File: tb/tb_simplez_sequencer.sv
// Bench for simplez_sequencer: fixed program table, hand-written corner
// sequences, and random programs checked against an instruction-level model.
module tb_simplez_sequencer;

`ifdef SIMPLEZ_SINGLE_STEP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk;
  logic        rstn;
`ifdef SIMPLEZ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [11:0] mem_rdata;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] ac;
  logic [8:0]  pc;
  logic        halted;

  logic [11:0] mem [512];
  int          mm  [512];

  int checks   = 0;
  int failures = 0;

  simplez_sequencer #(.ADDR_W(9), .DATA_W(12), .RESET_PC(0)) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef SIMPLEZ_SINGLE_STEP_EN
    .step      (step),
`endif
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .ac        (ac),
    .pc        (pc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: registered read on the falling edge, write committed there too.
  always @(negedge clk) begin
    mem_rdata = mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic hold_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 512; a++) mem[a] = 12'o0;
  endtask

  typedef struct {
    logic [11:0] prog [8];
    logic [11:0] d8;
    logic [11:0] d9;
    int          exp_pc;
    int          exp_ac;
    int          cyc;
    int          ninst;
    int          nst;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, wecnt;
`ifdef SIMPLEZ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    rstn = 1'b0;
    mem_rdata = 12'o0;
    clear_mem();

    vecs[0].prog = '{12'o1010, 12'o2011, 12'o0012, 12'o7000, 12'o0, 12'o0, 12'o0, 12'o0};
    vecs[0].d8 = 12'o0005; vecs[0].d9 = 12'o0003;
    vecs[0].exp_pc = 3; vecs[0].exp_ac = 'o10; vecs[0].cyc = 11; vecs[0].ninst = 4; vecs[0].nst = 1;
    vecs[1].prog = '{12'o5000, 12'o6000, 12'o7000, 12'o0, 12'o0, 12'o0, 12'o0, 12'o0};
    vecs[1].d8 = 12'o0; vecs[1].d9 = 12'o0;
    vecs[1].exp_pc = 2; vecs[1].exp_ac = 'o7777; vecs[1].cyc = 6; vecs[1].ninst = 3; vecs[1].nst = 0;
    vecs[2].prog = '{12'o5000, 12'o4005, 12'o0, 12'o0, 12'o0, 12'o7000, 12'o0, 12'o0};
    vecs[2].d8 = 12'o0; vecs[2].d9 = 12'o0;
    vecs[2].exp_pc = 5; vecs[2].exp_ac = 0; vecs[2].cyc = 6; vecs[2].ninst = 3; vecs[2].nst = 0;
    vecs[3].prog = '{12'o6000, 12'o4005, 12'o7000, 12'o0, 12'o0, 12'o7000, 12'o0, 12'o0};
    vecs[3].d8 = 12'o0; vecs[3].d9 = 12'o0;
    vecs[3].exp_pc = 2; vecs[3].exp_ac = 'o7777; vecs[3].cyc = 6; vecs[3].ninst = 3; vecs[3].nst = 0;
    vecs[4].prog = '{12'o3006, 12'o0, 12'o0, 12'o0, 12'o0, 12'o0, 12'o7000, 12'o0};
    vecs[4].d8 = 12'o0; vecs[4].d9 = 12'o0;
    vecs[4].exp_pc = 6; vecs[4].exp_ac = 0; vecs[4].cyc = 4; vecs[4].ninst = 2; vecs[4].nst = 0;
    // Self-modifying: ST overwrites the instruction fetched right after it.
    vecs[5].prog = '{12'o1010, 12'o0002, 12'o7000, 12'o0, 12'o0, 12'o7000, 12'o0, 12'o0};
    vecs[5].d8 = 12'o3005; vecs[5].d9 = 12'o0;
    vecs[5].exp_pc = 5; vecs[5].exp_ac = 'o3005; vecs[5].cyc = 10; vecs[5].ninst = 4; vecs[5].nst = 1;

    // ---- reset state ----
    hold_reset();
    hold_reset();
    chk("reset_pc", pc, 0);
    chk("reset_ac", ac, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_halted", halted, 0);

    // ---- table-driven programs ----
    for (int i = 0; i < 6; i++) begin
      hold_reset();
      clear_mem();
      for (int a = 0; a < 8; a++) mem[a] = vecs[i].prog[a];
      mem[8] = vecs[i].d8;
      mem[9] = vecs[i].d9;
      rstn = 1'b1;
      n = 0; wecnt = 0;
      while (!halted && n < 200) begin
        @(posedge clk); #1;
        n++;
        if (mem_we) wecnt++;
      end
      chk($sformatf("vec%0d_cycles", i), n, vecs[i].cyc + EXTRA * vecs[i].ninst);
      chk($sformatf("vec%0d_halted", i), halted, 1);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_ac", i), ac, vecs[i].exp_ac);
      chk($sformatf("vec%0d_we_cycles", i), wecnt, vecs[i].nst);
      if (i == 0) chk("vec0_mem10", mem[10], 'o10);
      if (i == 5) chk("vec5_mem2", mem[2], 'o3005);
      // Halted state is absorbing with outputs frozen.
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_frozen", i), {halted, mem_we, pc, ac}, {1'b1, 1'b0, 9'(vecs[i].exp_pc), 12'(vecs[i].exp_ac)});
    end

    // ---- PC / address wrap through 511 ----
    begin
      bit saw_we;
      hold_reset();
      clear_mem();
      mem[0] = 12'o3777;
      mem[511] = 12'o5000;
      rstn = 1'b1;
      saw_we = 0;
      for (int e = 1; e <= 12; e++) begin
        @(posedge clk); #1;
        if (mem_we) saw_we = 1;
        if (e == 2 + EXTRA) begin
          chk("wrap_br_addr", mem_addr, 511);
          chk("wrap_br_pc", pc, 511);
        end
        if (e == 4 + 2 * EXTRA) begin
          chk("wrap_clr_addr", mem_addr, 0);
          chk("wrap_clr_pc", pc, 0);
        end
      end
      chk("wrap_no_we", saw_we, 0);
    end

    // ---- reset during EXEC of ADD, then clean rerun ----
    hold_reset();
    clear_mem();
    for (int a = 0; a < 8; a++) mem[a] = vecs[0].prog[a];
    mem[8] = 12'o0005;
    mem[9] = 12'o0003;
    rstn = 1'b1;
    repeat (5 + 2 * EXTRA) @(posedge clk);
    #1;
    chk("midrst_ac_before", ac, 5);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", {pc, ac, mem_addr, mem_we, halted}, 0);
    rstn = 1'b1;
    n = 0;
    while (!halted && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_rerun_cycles", n, 11 + 4 * EXTRA);
    chk("midrst_rerun_ac", ac, 'o10);
    chk("midrst_rerun_mem10", mem[10], 'o10);

`ifdef SIMPLEZ_SINGLE_STEP_EN
    // ---- single step ----
    begin
      bit moved;
      hold_reset();
      clear_mem();
      for (int a = 0; a < 8; a++) mem[a] = vecs[0].prog[a];
      mem[8] = 12'o0005;
      mem[9] = 12'o0003;
      step = 1'b0;
      rstn = 1'b1;
      moved = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (pc != 0 || mem_we) moved = 1;
      end
      chk("step_idle", moved, 0);
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("step_one_pc", pc, 1);
      chk("step_one_ac", ac, 5);
      chk("step_one_addr", mem_addr, 1);
      step = 1'b1;
    end
`endif

    // ---- random programs against an instruction-level model ----
    for (int r = 0; r < 40; r++) begin
      int mpc, mac, w, op, cd, lat, wecnt2, old_ac, badmem;
      bit mh;
      hold_reset();
      for (int a = 0; a < 512; a++) begin
        mem[a] = 12'($urandom);
        mm[a] = int'(mem[a]);
      end
      mpc = 0; mac = 0; mh = 0;
      rstn = 1'b1;
      for (int k = 0; k < 30 && !mh; k++) begin
        w = mm[mpc]; op = w >> 9; cd = w & 511;
        old_ac = mac;
        lat = (op <= 2) ? 3 : 2;
        case (op)
          0: begin mm[cd] = mac; mpc = (mpc + 1) % 512; end
          1: begin mac = mm[cd]; mpc = (mpc + 1) % 512; end
          2: begin mac = (mac + mm[cd]) % 4096; mpc = (mpc + 1) % 512; end
          3: mpc = cd;
          4: mpc = (mac == 0) ? cd : (mpc + 1) % 512;
          5: begin mac = 0; mpc = (mpc + 1) % 512; end
          6: begin mac = (mac + 4095) % 4096; mpc = (mpc + 1) % 512; end
          default: mh = 1;
        endcase
        wecnt2 = 0;
        for (int c = 0; c < lat + EXTRA; c++) begin
          @(posedge clk); #1;
          if (mem_we) begin
            wecnt2++;
            chk("rnd_st_addr", mem_addr, cd);
            chk("rnd_st_wdata", mem_wdata, old_ac);
          end
        end
        chk("rnd_we_cycles", wecnt2, (op == 0) ? 1 : 0);
        chk("rnd_pc", pc, mpc);
        chk("rnd_ac", ac, mac);
        chk("rnd_halted", halted, mh);
        if (!mh) chk("rnd_next_addr", mem_addr, mpc);
      end
      badmem = 0;
      for (int a = 0; a < 512; a++) if (int'(mem[a]) != mm[a]) badmem++;
      chk("rnd_mem_image", badmem, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
